// File: rtl/axi_dmem_responder.sv
// ---------------------------------------------------------------------------
// axi_dmem_responder
//
// Single-beat AXI4-Lite-style data-memory responder. It sits at the target
// end of the ar/r and aw/w/b channels driven by the CPU memory stage. It holds
// a DEPTH x DATA_W synchronous array with byte-strobe writes and a
// programmable read latency. The read and write paths are independent FSMs,
// and each allows one outstanding transaction.
//
// Handshake semantics:
//   A transfer happens on the rising clk edge where valid && ready are both 1.
//   The ready outputs depend only on FSM state, never on the valids.
//   r_valid / b_valid stay high, with r_data / r_resp / b_resp held stable,
//   until the matching ready is seen.
//
// Word index: (addr - BASE_ADDR) >> 3, truncated to clog2(DEPTH) bits.
// addr[2:0] is ignored.
//
// Optional feature macro: AXI_DMEM_ADDR_CHECK_EN
//   When defined, addresses outside [BASE_ADDR, BASE_ADDR + DEPTH*8) return
//   DECERR (2'b11). Such a read returns zero data, and such a write leaves
//   the array untouched. When undefined, addresses wrap modulo DEPTH and
//   responses are always OKAY.
//
// Ports:
//   clk, reset             clock; synchronous active-high reset
//   ar_valid/ar_addr/ar_ready        read address channel
//   r_valid/r_data/r_resp/r_ready    read data channel
//   aw_valid/aw_addr/aw_ready        write address channel
//   w_valid/w_data/w_strb/w_ready    write data channel
//   b_valid/b_resp/b_ready           write response channel
//   r_state_dbg, w_state_dbg         current read / write FSM state (debug)
// ---------------------------------------------------------------------------
module axi_dmem_responder #(
  parameter int                ADDR_W    = 64,
  parameter int                DATA_W    = 64,
  parameter int                DEPTH     = 4096,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 64'h8000_0000,
  parameter int                READ_LAT  = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ar_valid,
  input  logic [ADDR_W-1:0]   ar_addr,
  output logic                ar_ready,
  output logic                r_valid,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          r_resp,
  input  logic                r_ready,
  input  logic                aw_valid,
  input  logic [ADDR_W-1:0]   aw_addr,
  output logic                aw_ready,
  input  logic                w_valid,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] w_strb,
  output logic                w_ready,
  output logic                b_valid,
  output logic [1:0]          b_resp,
  input  logic                b_ready,
  output logic [1:0]          r_state_dbg,
  output logic [1:0]          w_state_dbg
);

  localparam int STRB_W = DATA_W / 8;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } r_state_t;

  typedef enum logic [1:0] {
    W_IDLE   = 2'd0,
    W_HAVE_A = 2'd1,
    W_HAVE_D = 2'd2,
    W_RESP   = 2'd3
  } w_state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] addr);
    return IDX_W'((addr - BASE_ADDR) >> 3);
  endfunction

  // Address decode for both channels
  logic [IDX_W-1:0] ar_idx_in;
  logic [IDX_W-1:0] aw_idx_in;
  logic             ar_err_in;
  logic             aw_err_in;

  assign ar_idx_in = word_idx(ar_addr);
  assign aw_idx_in = word_idx(aw_addr);

`ifdef AXI_DMEM_ADDR_CHECK_EN
  // One extra bit so that BASE_ADDR + DEPTH*8 cannot overflow.
  localparam logic [ADDR_W:0] ADDR_LIMIT =
    {1'b0, BASE_ADDR} + ((ADDR_W+1)'(DEPTH) << 3);

  function automatic logic addr_err(input logic [ADDR_W-1:0] addr);
    return (addr < BASE_ADDR) || ({1'b0, addr} >= ADDR_LIMIT);
  endfunction

  assign ar_err_in = addr_err(ar_addr);
  assign aw_err_in = addr_err(aw_addr);
`else
  assign ar_err_in = 1'b0;
  assign aw_err_in = 1'b0;
`endif

  // ------------------------------------------------------------------
  // Read path
  // ------------------------------------------------------------------
  r_state_t         r_state;
  r_state_t         r_next;
  logic [3:0]       rd_cnt;
  logic [IDX_W-1:0] rd_idx_q;
  logic             rd_err_q;
  logic             ar_hs;
  logic             load_rdata;
  logic [IDX_W-1:0] rd_sel_idx;
  logic             rd_sel_err;

  assign ar_hs = ar_valid && ar_ready;

  always_ff @(posedge clk) begin
    if (reset) r_state <= R_IDLE;
    else       r_state <= r_next;
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE: if (ar_hs) r_next = (READ_LAT == 1) ? R_RESP : R_WAIT;
      R_WAIT: if (rd_cnt == 4'd1) r_next = R_RESP;
      R_RESP: if (r_ready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    ar_ready = 1'b0;
    r_valid  = 1'b0;
    case (r_state)
      R_IDLE:  ar_ready = 1'b1;
      R_RESP:  r_valid  = 1'b1;
      default: ;
    endcase
  end

  assign r_state_dbg = r_state;

  always_ff @(posedge clk) begin
    if (reset)                  rd_cnt <= '0;
    else if (ar_hs)             rd_cnt <= 4'(READ_LAT - 1);
    else if (r_state == R_WAIT) rd_cnt <= rd_cnt - 4'd1;
  end

  always_ff @(posedge clk) begin
    if (ar_hs) begin
      rd_idx_q <= ar_idx_in;
      rd_err_q <= ar_err_in;
    end
  end

  // With READ_LAT==1 the array is read on the handshake edge itself, so the
  // index comes straight from the bus rather than from the latch.
  assign rd_sel_idx = (r_state == R_IDLE) ? ar_idx_in : rd_idx_q;
  assign rd_sel_err = (r_state == R_IDLE) ? ar_err_in : rd_err_q;
  assign load_rdata = (r_state != R_RESP) && (r_next == R_RESP);

  // The non-blocking array read makes a same-edge write invisible here,
  // which gives read-before-write ordering.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_data <= '0;
      r_resp <= 2'b00;
    end else if (load_rdata) begin
      if (rd_sel_err) begin
        r_data <= '0;
        r_resp <= 2'b11;
      end else begin
        r_data <= mem[rd_sel_idx];
        r_resp <= 2'b00;
      end
    end
  end

  // ------------------------------------------------------------------
  // Write path
  // ------------------------------------------------------------------
  w_state_t          w_state;
  w_state_t          w_next;
  logic              aw_hs;
  logic              w_hs;
  logic              commit;
  logic              commit_wr;
  logic [IDX_W-1:0]  aw_idx_q;
  logic              aw_err_q;
  logic [DATA_W-1:0] w_data_q;
  logic [STRB_W-1:0] w_strb_q;
  logic [IDX_W-1:0]  commit_idx;
  logic              commit_err;
  logic [DATA_W-1:0] commit_data;
  logic [STRB_W-1:0] commit_strb;

  assign aw_hs = aw_valid && aw_ready;
  assign w_hs  = w_valid && w_ready;

  always_ff @(posedge clk) begin
    if (reset) w_state <= W_IDLE;
    else       w_state <= w_next;
  end

  always_comb begin
    w_next = w_state;
    commit = 1'b0;
    case (w_state)
      W_IDLE: begin
        if (aw_hs && w_hs) begin
          commit = 1'b1;
          w_next = W_RESP;
        end else if (aw_hs) begin
          w_next = W_HAVE_A;
        end else if (w_hs) begin
          w_next = W_HAVE_D;
        end
      end
      W_HAVE_A: if (w_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_HAVE_D: if (aw_hs) begin
        commit = 1'b1;
        w_next = W_RESP;
      end
      W_RESP: if (b_ready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    aw_ready = 1'b0;
    w_ready  = 1'b0;
    b_valid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        aw_ready = 1'b1;
        w_ready  = 1'b1;
      end
      W_HAVE_A: w_ready  = 1'b1;
      W_HAVE_D: aw_ready = 1'b1;
      W_RESP:   b_valid  = 1'b1;
      default: ;
    endcase
  end

  assign w_state_dbg = w_state;

  always_ff @(posedge clk) begin
    if (aw_hs) begin
      aw_idx_q <= aw_idx_in;
      aw_err_q <= aw_err_in;
    end
    if (w_hs) begin
      w_data_q <= w_data;
      w_strb_q <= w_strb;
    end
  end

  // Whichever half was latched earlier comes from its holding register.
  // The other half comes from the bus on the commit edge.
  assign commit_idx  = (w_state == W_HAVE_A) ? aw_idx_q : aw_idx_in;
  assign commit_err  = (w_state == W_HAVE_A) ? aw_err_q : aw_err_in;
  assign commit_data = (w_state == W_HAVE_D) ? w_data_q : w_data;
  assign commit_strb = (w_state == W_HAVE_D) ? w_strb_q : w_strb;

  // Reset drops any in-flight write, including one completing on the reset
  // cycle itself.
  assign commit_wr = commit && !reset && !commit_err;

  always_ff @(posedge clk) begin
    if (commit_wr) begin
      for (int i = 0; i < STRB_W; i++) begin
        if (commit_strb[i]) mem[commit_idx][8*i +: 8] <= commit_data[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset)       b_resp <= 2'b00;
    else if (commit) b_resp <= commit_err ? 2'b11 : 2'b00;
  end

endmodule
